// File: rtl/conv_loader_pkg.sv
// Shared state encoding and size helpers for the convolution loader.
package conv_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int calc_nk(input int k0, input int k1, input int ic, input int oc);
        return k0 * k1 * ic * oc;
    endfunction

    // Kernel weights, one bias per output channel, then MACC coefficient and layer scale.
    function automatic int calc_nw(input int nk, input int oc);
        return nk + oc + 2;
    endfunction

    function automatic int calc_ppf(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/conv_loader_cnt.sv
// Wrap counter: counts 0..MAX on en, returns to 0 after MAX, clr has priority.
module conv_loader_cnt #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign tc = (count == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/conv_loader.sv
// Loads weights into the conv weight memory, then streams pixel frames into the conv FIFO.
module conv_loader
    import conv_loader_pkg::*;
#(
    parameter int IN_WIDTH              = 4,
    parameter int IN_HEIGHT             = 4,
    parameter int IN_CHANNEL            = 2,
    parameter int OUT_CHANNEL           = 2,
    parameter int KERNEL_0              = 3,
    parameter int KERNEL_1              = 3,
    parameter int KERNEL_BASE_ADDR      = 0,
    parameter int BIAS_BASE_ADDR        = KERNEL_BASE_ADDR + calc_nk(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL),
    parameter int MACC_COEFF_BASE_ADDR  = BIAS_BASE_ADDR + OUT_CHANNEL,
    parameter int LAYER_SCALE_BASE_ADDR = MACC_COEFF_BASE_ADDR + 1,
    parameter int FRAMES                = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             w_data,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [8*IN_CHANNEL-1:0] px_data,
    input  logic                    px_valid,
    output logic                    px_ready,
    input  logic                    fifo_rd_en,
    input  logic                    fifo_almost_full,
    output logic [31:0]             weight_wr_data,
    output logic [31:0]             weight_wr_addr,
    output logic                    weight_wr_en,
    output logic [8*IN_CHANNEL-1:0] i_data,
    output logic                    i_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    frame_done
);

    localparam int NK        = calc_nk(KERNEL_0, KERNEL_1, IN_CHANNEL, OUT_CHANNEL);
    localparam int NW        = calc_nw(NK, OUT_CHANNEL);
    localparam int PPF       = calc_ppf(IN_WIDTH, IN_HEIGHT);
    localparam int WCW       = $clog2(NW + 1);
    localparam int PCW       = $clog2(PPF + 1);
    localparam int FCW       = (FRAMES == 0) ? 16 : $clog2(FRAMES + 1);
    localparam int FRAME_MAX = (FRAMES == 0) ? 65535 : FRAMES - 1;

    state_t             state, state_nxt;
    logic               w_accept, px_accept, run_start, cnt_clr;
    logic [WCW-1:0]     word_cnt;
    logic [PCW-1:0]     pix_cnt;
    logic [FCW-1:0]     frm_cnt;
    logic               word_tc, pix_tc, frm_tc;
    logic               cnt_unused;

    logic                    wr_vld_p1;
    logic [31:0]             wr_data_p1;
    logic [31:0]             wr_addr_p1;
    logic                    px_vld_p1;
    logic [8*IN_CHANNEL-1:0] px_data_p1;
    logic                    frame_last_p1;

    // Word index to weight-memory address; the four regions may sit anywhere.
    function automatic logic [31:0] word_addr(input logic [WCW-1:0] n);
        int idx = int'(n);
        if (idx < NK)                     return 32'(KERNEL_BASE_ADDR + idx);
        else if (idx < NK + OUT_CHANNEL)  return 32'(BIAS_BASE_ADDR + idx - NK);
        else if (idx == NK + OUT_CHANNEL) return 32'(MACC_COEFF_BASE_ADDR);
        return 32'(LAYER_SCALE_BASE_ADDR);
    endfunction

    assign run_start  = start && (state == IDLE || state == DONE);
    assign cnt_clr    = abort || run_start;
    assign w_accept   = w_valid && w_ready;
    assign px_accept  = px_valid && px_ready;
    assign cnt_unused = ^{pix_cnt, frm_cnt};

    conv_loader_cnt #(.WIDTH(WCW), .MAX(NW - 1)) u_word_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(w_accept),
        .count(word_cnt), .tc(word_tc)
    );

    conv_loader_cnt #(.WIDTH(PCW), .MAX(PPF - 1)) u_pix_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(px_accept),
        .count(pix_cnt), .tc(pix_tc)
    );

    conv_loader_cnt #(.WIDTH(FCW), .MAX(FRAME_MAX)) u_frm_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .en(px_accept && pix_tc),
        .count(frm_cnt), .tc(frm_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Ready is withheld during abort so no handshake completes in that cycle.
    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        px_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LOAD_W;
            end
            LOAD_W: begin
                busy    = 1'b1;
                w_ready = !abort;
                if (w_valid && w_ready && word_tc) state_nxt = STREAM;
            end
            STREAM: begin
                busy     = 1'b1;
                px_ready = fifo_rd_en && !fifo_almost_full && !abort;
                if (px_valid && px_ready && pix_tc && (FRAMES != 0) && frm_tc)
                    state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD_W;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // p1: accepted word / pixel registered toward the conv block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p1     <= 1'b0;
            wr_data_p1    <= '0;
            wr_addr_p1    <= '0;
            px_vld_p1     <= 1'b0;
            px_data_p1    <= '0;
            frame_last_p1 <= 1'b0;
        end else begin
            wr_vld_p1     <= w_accept;
            px_vld_p1     <= px_accept;
            frame_last_p1 <= px_accept && pix_tc;
            if (w_accept) begin
                wr_data_p1 <= w_data;
                wr_addr_p1 <= word_addr(word_cnt);
            end
            if (px_accept) px_data_p1 <= px_data;
        end
    end

    assign weight_wr_en   = wr_vld_p1;
    assign weight_wr_data = wr_data_p1;
    assign weight_wr_addr = wr_addr_p1;
    assign i_valid        = px_vld_p1;
    assign i_data         = px_data_p1;
    assign frame_done     = frame_last_p1;

endmodule

// File: tb/tb_conv_loader.sv
// Directed bench for conv_loader: default map, non-contiguous map and continuous-frame instances.
module tb_conv_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, w_valid, px_valid, fifo_rd_en, fifo_almost_full;
    logic [31:0] w_data;
    logic [15:0] px_data;

    logic        a_w_ready, a_px_ready, a_wr_en, a_i_valid, a_busy, a_done, a_frame_done;
    logic [31:0] a_wr_data, a_wr_addr;
    logic [15:0] a_i_data;
    logic        n_w_ready, n_px_ready, n_wr_en, n_i_valid, n_busy, n_done, n_frame_done;
    logic [31:0] n_wr_data, n_wr_addr;
    logic [15:0] n_i_data;
    logic        c_w_ready, c_px_ready, c_wr_en, c_i_valid, c_busy, c_done, c_frame_done;
    logic [31:0] c_wr_data, c_wr_addr;
    logic [15:0] c_i_data;

    int n_tests = 0;
    int n_fail  = 0;
    int c_frames = 0;

    always #5 clk = ~clk;

    conv_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .w_data(w_data), .w_valid(w_valid), .w_ready(a_w_ready),
        .px_data(px_data), .px_valid(px_valid), .px_ready(a_px_ready),
        .fifo_rd_en(fifo_rd_en), .fifo_almost_full(fifo_almost_full),
        .weight_wr_data(a_wr_data), .weight_wr_addr(a_wr_addr), .weight_wr_en(a_wr_en),
        .i_data(a_i_data), .i_valid(a_i_valid), .busy(a_busy), .done(a_done),
        .frame_done(a_frame_done)
    );

    conv_loader #(.BIAS_BASE_ADDR(100), .MACC_COEFF_BASE_ADDR(200), .LAYER_SCALE_BASE_ADDR(300)) dut_nc (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .w_data(w_data), .w_valid(w_valid), .w_ready(n_w_ready),
        .px_data(px_data), .px_valid(px_valid), .px_ready(n_px_ready),
        .fifo_rd_en(fifo_rd_en), .fifo_almost_full(fifo_almost_full),
        .weight_wr_data(n_wr_data), .weight_wr_addr(n_wr_addr), .weight_wr_en(n_wr_en),
        .i_data(n_i_data), .i_valid(n_i_valid), .busy(n_busy), .done(n_done),
        .frame_done(n_frame_done)
    );

    conv_loader #(.FRAMES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .w_data(w_data), .w_valid(w_valid), .w_ready(c_w_ready),
        .px_data(px_data), .px_valid(px_valid), .px_ready(c_px_ready),
        .fifo_rd_en(fifo_rd_en), .fifo_almost_full(fifo_almost_full),
        .weight_wr_data(c_wr_data), .weight_wr_addr(c_wr_addr), .weight_wr_en(c_wr_en),
        .i_data(c_i_data), .i_valid(c_i_valid), .busy(c_busy), .done(c_done),
        .frame_done(c_frame_done)
    );

    // Expected address for the instance with bias/coeff/scale at 100/200/300.
    function automatic logic [31:0] nc_addr(input int k);
        if (k < 36)  return 32'(k);
        if (k < 38)  return 32'(100 + k - 36);
        if (k == 38) return 32'd200;
        return 32'd300;
    endfunction

    task automatic do_load();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; w_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w_data = 32'h100 + 32'(k);
            @(negedge clk);
        end
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = '0;
        px_valid = 1'b0; px_data = '0; fifo_rd_en = 1'b1; fifo_almost_full = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({a_wr_en, a_i_valid, a_w_ready, a_px_ready, a_busy, a_done, a_frame_done} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000000",
                {a_wr_en, a_i_valid, a_w_ready, a_px_ready, a_busy, a_done, a_frame_done});
        end
        n_tests++;
        if ({a_wr_data, a_wr_addr, a_i_data} !== 80'd0) begin
            n_fail++; $display("FAIL reset_data: data %h addr %h px %h want 0", a_wr_data, a_wr_addr, a_i_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_busy, a_done, a_w_ready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_idle: busy/done/w_ready %b want 000", {a_busy, a_done, a_w_ready});
        end
    endtask

    task automatic test_weight_load();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_tests++;
        if ({a_busy, a_w_ready, a_wr_en} !== 3'b110) begin
            n_fail++; $display("FAIL load_enter: busy/w_ready/wr_en %b want 110", {a_busy, a_w_ready, a_wr_en});
        end
        w_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            w_data = 32'(k);
            @(negedge clk);
            n_tests++;
            if ({a_wr_en, a_wr_data, a_wr_addr} !== {1'b1, 32'(k), 32'(k)}) begin
                n_fail++; $display("FAIL load_word[%0d]: en %b data %0d addr %0d want 1 %0d %0d",
                    k, a_wr_en, a_wr_data, a_wr_addr, k, k);
            end
            n_tests++;
            if ({n_wr_en, n_wr_addr} !== {1'b1, nc_addr(k)}) begin
                n_fail++; $display("FAIL nc_addr[%0d]: en %b addr %0d want 1 %0d", k, n_wr_en, n_wr_addr, nc_addr(k));
            end
        end
        w_valid = 1'b0;
        n_tests++;
        if ({a_busy, a_w_ready, a_px_ready, c_px_ready} !== 4'b1011) begin
            n_fail++; $display("FAIL load_to_stream: busy/w_ready/px_ready/c_px_ready %b want 1011",
                {a_busy, a_w_ready, a_px_ready, c_px_ready});
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            exp = 16'h0101 * 16'(i + 1);
            px_valid = 1'b1; px_data = exp;
            @(negedge clk);
            n_tests++;
            if ({a_i_valid, a_i_data, a_frame_done} !== {1'b1, exp, (i == 15)}) begin
                n_fail++; $display("FAIL stream_px[%0d]: valid %b data %h fd %b want 1 %h %b",
                    i, a_i_valid, a_i_data, a_frame_done, exp, (i == 15));
            end
            if (c_frame_done) c_frames++;
        end
        px_valid = 1'b0;
        n_tests++;
        if ({a_done, a_busy, c_done, c_busy} !== 4'b1001) begin
            n_fail++; $display("FAIL stream_end: a_done/a_busy/c_done/c_busy %b want 1001",
                {a_done, a_busy, c_done, c_busy});
        end
        @(negedge clk);
        n_tests++;
        if ({a_i_valid, a_i_data} !== {1'b0, 16'h1010}) begin
            n_fail++; $display("FAIL stream_hold: valid %b data %h want 0 1010", a_i_valid, a_i_data);
        end
    endtask

    task automatic test_continuous();
        for (int i = 0; i < 32; i++) begin
            px_valid = 1'b1; px_data = 16'h2000 + 16'(i);
            @(negedge clk);
            n_tests++;
            if ({c_i_valid, c_i_data, c_frame_done} !== {1'b1, 16'h2000 + 16'(i), (i == 15 || i == 31)}) begin
                n_fail++; $display("FAIL cont_px[%0d]: valid %b data %h fd %b", i, c_i_valid, c_i_data, c_frame_done);
            end
            if (c_frame_done) c_frames++;
        end
        px_valid = 1'b0;
        n_tests++;
        if (c_frames !== 3 || c_done !== 1'b0 || c_busy !== 1'b1) begin
            n_fail++; $display("FAIL cont_frames: frames %0d done %b busy %b want 3 0 1", c_frames, c_done, c_busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] af_pat;
        logic        exp_acc;
        int          idx;
        int          c;
        af_pat = 32'hA5C3_6E19;
        idx = 0;
        c = 0;
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_tests++;
        if ({a_busy, a_done, c_busy} !== 3'b000) begin
            n_fail++; $display("FAIL abort_idle: a_busy/a_done/c_busy %b want 000", {a_busy, a_done, c_busy});
        end
        do_load();
        while (idx < 16 && c < 100) begin
            fifo_almost_full = af_pat[c % 32];
            fifo_rd_en = !(c >= 6 && c < 11);
            px_valid = 1'b1; px_data = 16'h3000 + 16'(idx);
            exp_acc = fifo_rd_en && !fifo_almost_full;
            #1;
            n_tests++;
            if (a_px_ready !== exp_acc) begin
                n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", c, a_px_ready, exp_acc);
            end
            @(negedge clk);
            n_tests++;
            if (a_i_valid !== exp_acc || (exp_acc && a_i_data !== 16'h3000 + 16'(idx))) begin
                n_fail++; $display("FAIL bp_out[%0d]: valid %b data %h want %b %h",
                    c, a_i_valid, a_i_data, exp_acc, 16'h3000 + 16'(idx));
            end
            if (exp_acc) idx++;
            c++;
        end
        px_valid = 1'b0; fifo_almost_full = 1'b0; fifo_rd_en = 1'b1;
        n_tests++;
        if (idx !== 16 || a_done !== 1'b1) begin
            n_fail++; $display("FAIL bp_complete: pixels %0d done %b want 16 1", idx, a_done);
        end
    endtask

    task automatic test_abort_restart();
        do_load();
        for (int i = 0; i < 7; i++) begin
            px_valid = 1'b1; px_data = 16'h4000 + 16'(i);
            @(negedge clk);
        end
        n_tests++;
        if ({a_i_valid, a_i_data} !== {1'b1, 16'h4006}) begin
            n_fail++; $display("FAIL abort_pre: valid %b data %h want 1 4006", a_i_valid, a_i_data);
        end
        px_data = 16'h4007; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; px_valid = 1'b0;
        n_tests++;
        if ({a_i_valid, a_busy, a_done, a_frame_done} !== 4'b0000) begin
            n_fail++; $display("FAIL abort_cut: valid/busy/done/fd %b want 0000",
                {a_i_valid, a_busy, a_done, a_frame_done});
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0; w_valid = 1'b1; w_data = 32'h55;
        @(negedge clk);
        n_tests++;
        if ({a_wr_en, a_wr_data, a_wr_addr} !== {1'b1, 32'h55, 32'd0}) begin
            n_fail++; $display("FAIL restart_word0: en %b data %h addr %0d want 1 55 0", a_wr_en, a_wr_data, a_wr_addr);
        end
        for (int k = 1; k < 40; k++) begin
            w_data = 32'(k);
            @(negedge clk);
        end
        w_valid = 1'b0;
        n_tests++;
        if ({a_wr_en, a_wr_addr, a_busy, a_px_ready} !== {1'b1, 32'd39, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL restart_load: en %b addr %0d busy %b px_ready %b want 1 39 1 1",
                a_wr_en, a_wr_addr, a_busy, a_px_ready);
        end
        for (int i = 0; i < 16; i++) begin
            px_valid = 1'b1; px_data = 16'h5000 + 16'(i);
            @(negedge clk);
            n_tests++;
            if ({a_i_valid, a_frame_done} !== {1'b1, (i == 15)}) begin
                n_fail++; $display("FAIL restart_px[%0d]: valid %b fd %b want 1 %b", i, a_i_valid, a_frame_done, (i == 15));
            end
        end
        px_valid = 1'b0;
        n_tests++;
        if (a_done !== 1'b1) begin
            n_fail++; $display("FAIL restart_done: got %b want 1", a_done);
        end
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        @(negedge clk); start = 1'b0; w_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w_data = 32'h700 + 32'(k);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({a_wr_en, a_i_valid, a_w_ready, a_px_ready, a_busy, a_done, a_frame_done} !== 7'b0) begin
            n_fail++; $display("FAIL midrst_ctrl: got %b want 0000000",
                {a_wr_en, a_i_valid, a_w_ready, a_px_ready, a_busy, a_done, a_frame_done});
        end
        n_tests++;
        if ({a_wr_data, a_wr_addr, a_i_data} !== 80'd0) begin
            n_fail++; $display("FAIL midrst_data: data %h addr %h px %h want 0", a_wr_data, a_wr_addr, a_i_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_busy, a_w_ready, a_wr_en, a_done, a_i_valid} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_release: busy/w_ready/wr_en/done/i_valid %b want 00000",
                {a_busy, a_w_ready, a_wr_en, a_done, a_i_valid});
        end
        @(negedge clk);
        n_tests++;
        if (a_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_nowrite: wr_en %b want 0", a_wr_en);
        end
        w_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_weight_load();
        test_stream();
        test_continuous();
        test_backpressure();
        test_abort_restart();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
